// File: rtl/program_loader.sv
// program_loader: boot-time image loader in front of the single-cycle MIPS core.
// Takes a byte stream (2-byte big-endian word count N, then 4*N bytes, each
// word MSB first), assembles 32-bit words and writes them to instruction memory
// at byte addresses 0, 4, 8, ... The core is held in reset until the whole
// image has been written; a bad length header parks the loader in ERR.
//
// Handshake: a byte moves on a rising edge where byte_valid & byte_ready are
// both 1. byte_ready never depends on byte_valid, and byte_in is ignored on
// any edge without a transfer. A producer may hold byte_valid high through the
// WRITE cycle; that byte simply waits and is taken in the next WORD cycle.
module program_loader #(
    parameter int MAX_WORDS = 256
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  byte_in,
    input  logic        byte_valid,
    output logic        byte_ready,
    output logic        imem_we,
    output logic [31:0] imem_addr,
    output logic [31:0] imem_wdata,
    output logic        core_rst,
    output logic        done,
    output logic        error,
    output logic [2:0]  o_dbg_state
);

    localparam logic [2:0] S_LEN_HI = 3'd0;
    localparam logic [2:0] S_LEN_LO = 3'd1;
    localparam logic [2:0] S_WORD   = 3'd2;
    localparam logic [2:0] S_WRITE  = 3'd3;
    localparam logic [2:0] S_DONE   = 3'd4;
    localparam logic [2:0] S_ERR    = 3'd5;

    // One extra bit so a 16-bit count can be compared against MAX_WORDS safely.
    localparam logic [16:0] LP_MAX_WORDS = 17'(MAX_WORDS);

    logic [2:0]  r_state;
    logic [7:0]  r_len_hi;
    logic [15:0] r_n;
    logic [23:0] r_word;       // first three bytes of the word being assembled
    logic [1:0]  r_byte_idx;
    logic [15:0] r_word_idx;
    logic        r_imem_we;
    logic [31:0] r_imem_addr;
    logic [31:0] r_imem_wdata;

    logic        w_ready;
    logic        w_xfer;
    logic [15:0] w_len;
    logic        w_len_bad;
    logic        w_last_word;
    logic        w_word_complete;

    // Handshake, header decode and end-of-word / end-of-image detection.
    always_comb begin
        w_ready         = 1'b0;
        w_xfer          = 1'b0;
        w_len           = {r_len_hi, byte_in};
        w_len_bad       = 1'b0;
        w_last_word     = 1'b0;
        w_word_complete = 1'b0;

        if (!rst) begin
            w_ready = (r_state == S_LEN_HI) || (r_state == S_LEN_LO) || (r_state == S_WORD);
        end
        w_xfer          = w_ready & byte_valid;
        w_len_bad       = (w_len == 16'd0) || ({1'b0, w_len} > LP_MAX_WORDS);
        w_last_word     = (r_word_idx == (r_n - 16'd1));
        w_word_complete = (r_state == S_WORD) && w_xfer && (r_byte_idx == 2'd3);
    end

    // Main loader FSM: header capture, byte assembly, word sequencing.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= S_LEN_HI;
            r_len_hi   <= 8'd0;
            r_n        <= 16'd0;
            r_word     <= 24'd0;
            r_byte_idx <= 2'd0;
            r_word_idx <= 16'd0;
        end else begin
            case (r_state)
                S_LEN_HI: begin
                    if (w_xfer) begin
                        r_len_hi <= byte_in;
                        r_state  <= S_LEN_LO;
                    end
                end
                S_LEN_LO: begin
                    if (w_xfer) begin
                        r_n        <= w_len;
                        r_byte_idx <= 2'd0;
                        r_word_idx <= 16'd0;
                        r_state    <= w_len_bad ? S_ERR : S_WORD;
                    end
                end
                S_WORD: begin
                    if (w_xfer) begin
                        r_word     <= {r_word[15:0], byte_in};
                        // Wraps to 0 on the fourth byte, ready for the next word.
                        r_byte_idx <= r_byte_idx + 2'd1;
                        if (r_byte_idx == 2'd3) begin
                            r_state <= S_WRITE;
                        end
                    end
                end
                S_WRITE: begin
                    if (w_last_word) begin
                        r_state <= S_DONE;
                    end else begin
                        r_word_idx <= r_word_idx + 16'd1;
                        r_state    <= S_WORD;
                    end
                end
                S_DONE: r_state <= S_DONE;
                S_ERR:  r_state <= S_ERR;
                default: r_state <= S_LEN_HI;
            endcase
        end
    end

    // Registered write port: loaded together on the fourth byte, so the strobe,
    // address and data are all valid in the WRITE cycle; address/data hold after.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_imem_we    <= 1'b0;
            r_imem_addr  <= 32'd0;
            r_imem_wdata <= 32'd0;
        end else begin
            r_imem_we <= w_word_complete;
            if (w_word_complete) begin
                r_imem_addr  <= {14'd0, r_word_idx, 2'b00};
                r_imem_wdata <= {r_word, byte_in};
            end
        end
    end

    assign byte_ready  = w_ready;
    assign imem_we     = r_imem_we;
    assign imem_addr   = r_imem_addr;
    assign imem_wdata  = r_imem_wdata;
    assign done        = (r_state == S_DONE);
    assign error       = (r_state == S_ERR);
    assign core_rst    = (r_state != S_DONE);
    assign o_dbg_state = r_state;

endmodule
